// File: rtl/joy_input_conditioner.sv
// DB9 joystick conditioner: 2-flop sync, per-bit debounce, edge pulses, long-press reset, NMI pulse.
// Optional JOY_AUTOFIRE_EN adds a per-channel autofire square wave on the fire bit.

module joy_debounce_lane #(
    parameter int C_debounce_bits = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic q,
    output logic rise,
    output logic fall
);
    localparam logic [C_debounce_bits-1:0] CNT_MAX = '1;

    logic [C_debounce_bits-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                q    <= s;
                cnt  <= '0;
                rise <= s;
                fall <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module joy_input_conditioner #(
    parameter int C_channels      = 2,
    parameter int C_buttons       = 6,
    parameter int C_debounce_bits = 16,
    parameter int C_hold_bits     = 24,
    parameter int C_reset_bit     = 11,
    parameter int C_nmi_bit       = 10
`ifdef JOY_AUTOFIRE_EN
    ,
    parameter int C_autofire_bits = 20
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [C_channels*C_buttons-1:0] n_joy,
`ifdef JOY_AUTOFIRE_EN
    input  logic [C_channels-1:0]           autofire_en,
`endif
    output logic [C_channels*C_buttons-1:0] joy,
    output logic [C_channels*C_buttons-1:0] joy_rise,
    output logic [C_channels*C_buttons-1:0] joy_fall,
    output logic                           btn_reset,
    output logic                           btn_nmi
);
    localparam int N = C_channels * C_buttons;
    localparam logic [C_hold_bits-1:0] HC_MAX = '1;

    logic [N-1:0] n_s1, n_s2;
    logic [N-1:0] joy_db;
    logic [C_hold_bits-1:0] hc;

    // Sync chain carries the raw active-low pins, so reset parks it at "released".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_s1 <= '1;
            n_s2 <= '1;
        end else begin
            n_s1 <= n_joy;
            n_s2 <= n_s1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        joy_debounce_lane #(.C_debounce_bits(C_debounce_bits)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .s    (~n_s2[i]),
            .q    (joy_db[i]),
            .rise (joy_rise[i]),
            .fall (joy_fall[i])
        );
    end

    // btn_reset rises on the same edge hc reaches max, i.e. after 2**C_hold_bits-1 held clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hc        <= '0;
            btn_reset <= 1'b0;
            btn_nmi   <= 1'b0;
        end else begin
            btn_nmi <= joy_rise[C_nmi_bit];
            if (!joy_db[C_reset_bit]) begin
                hc        <= '0;
                btn_reset <= 1'b0;
            end else begin
                if (hc != HC_MAX)
                    hc <= hc + 1'b1;
                btn_reset <= (hc == HC_MAX) || (hc == HC_MAX - 1'b1);
            end
        end
    end

`ifdef JOY_AUTOFIRE_EN
    logic [C_autofire_bits-1:0] af;

    always_ff @(posedge clk) begin
        if (!rst_n)
            af <= '0;
        else
            af <= af + 1'b1;
    end

    // Only the visible level is modulated; edge pulses stay on the debounced state.
    always_comb begin
        joy = joy_db;
        for (int c = 0; c < C_channels; c++) begin
            if (autofire_en[c] && joy_db[c*C_buttons+4])
                joy[c*C_buttons+4] = af[C_autofire_bits-1];
        end
    end
`else
    assign joy = joy_db;
`endif
endmodule

// File: tb/tb_joy_input_conditioner.sv
// Directed self-checking bench for joy_input_conditioner (C_debounce_bits=4, C_hold_bits=6).
`timescale 1ns/1ps

module tb_joy_input_conditioner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] n_joy;
    logic [1:0]  autofire_en;
    logic [11:0] joy, joy_rise, joy_fall;
    logic        btn_reset, btn_nmi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    joy_input_conditioner #(
        .C_channels(2), .C_buttons(6), .C_debounce_bits(4), .C_hold_bits(6),
        .C_reset_bit(11), .C_nmi_bit(10)
`ifdef JOY_AUTOFIRE_EN
        , .C_autofire_bits(3)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .n_joy(n_joy),
`ifdef JOY_AUTOFIRE_EN
        .autofire_en(autofire_en),
`endif
        .joy(joy),
        .joy_rise(joy_rise),
        .joy_fall(joy_fall),
        .btn_reset(btn_reset),
        .btn_nmi(btn_nmi)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if ({joy, joy_rise, joy_fall, btn_reset, btn_nmi} !== '0) begin
            failures++;
            $display("FAIL reset_state: joy=%h rise=%h fall=%h rst=%b nmi=%b expected all 0",
                     joy, joy_rise, joy_fall, btn_reset, btn_nmi);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            checks++;
            if ({joy, joy_rise, joy_fall, btn_reset, btn_nmi} !== '0) begin
                failures++;
                $display("FAIL idle_after_reset cyc %0d: joy=%h rise=%h fall=%h rst=%b nmi=%b expected 0",
                         k, joy, joy_rise, joy_fall, btn_reset, btn_nmi);
            end
        end
    endtask

    task automatic test_press_release;
        n_joy[4] = 1'b0;
        tick(17);
        checks++;
        if (joy !== 12'h000) begin failures++; $display("FAIL press_early: joy=%h expected 000", joy); end
        tick(1);
        checks++;
        if (joy !== 12'h010 || joy_rise !== 12'h010) begin
            failures++; $display("FAIL press_18: joy=%h rise=%h expected 010/010", joy, joy_rise);
        end
        tick(1);
        checks++;
        if (joy_rise !== 12'h000 || joy !== 12'h010) begin
            failures++; $display("FAIL press_pulse_width: joy=%h rise=%h expected 010/000", joy, joy_rise);
        end
        n_joy[4] = 1'b1;
        tick(17);
        checks++;
        if (joy !== 12'h010 || joy_fall !== 12'h000) begin
            failures++; $display("FAIL release_early: joy=%h fall=%h expected 010/000", joy, joy_fall);
        end
        tick(1);
        checks++;
        if (joy !== 12'h000 || joy_fall !== 12'h010) begin
            failures++; $display("FAIL release_18: joy=%h fall=%h expected 000/010", joy, joy_fall);
        end
        tick(1);
        checks++;
        if (joy_fall !== 12'h000) begin failures++; $display("FAIL fall_width: fall=%h expected 000", joy_fall); end
    endtask

    task automatic test_glitch_bounce;
        n_joy[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) n_joy[0] = 1'b1;
            tick(1);
            checks++;
            if ({joy, joy_rise, joy_fall} !== '0) begin
                failures++; $display("FAIL glitch cyc %0d: joy=%h rise=%h fall=%h expected 0", k, joy, joy_rise, joy_fall);
            end
        end
        // three short bounces, then settle low
        for (int b = 0; b < 6; b++) begin
            n_joy[0] = b[0];
            tick(3);
        end
        n_joy[0] = 1'b0;
        tick(17);
        checks++;
        if (joy !== 12'h000 || joy_rise !== 12'h000) begin
            failures++; $display("FAIL bounce_early: joy=%h rise=%h expected 000/000", joy, joy_rise);
        end
        tick(1);
        checks++;
        if (joy !== 12'h001 || joy_rise !== 12'h001) begin
            failures++; $display("FAIL bounce_settle: joy=%h rise=%h expected 001/001", joy, joy_rise);
        end
        n_joy[0] = 1'b1;
        tick(20);
    endtask

    task automatic test_hold;
        n_joy[11] = 1'b0;
        tick(18);
        checks++;
        if (joy !== 12'h800 || btn_reset !== 1'b0) begin
            failures++; $display("FAIL hold_joy: joy=%h rst=%b expected 800/0", joy, btn_reset);
        end
        tick(62);
        checks++;
        if (btn_reset !== 1'b0) begin failures++; $display("FAIL hold_80: rst=%b expected 0", btn_reset); end
        tick(1);
        checks++;
        if (btn_reset !== 1'b1) begin failures++; $display("FAIL hold_81: rst=%b expected 1", btn_reset); end
        tick(20);
        checks++;
        if (btn_reset !== 1'b1) begin failures++; $display("FAIL hold_sat: rst=%b expected 1", btn_reset); end
        n_joy[11] = 1'b1;
        tick(18);
        checks++;
        if (joy !== 12'h000 || joy_fall !== 12'h800 || btn_reset !== 1'b1) begin
            failures++; $display("FAIL hold_release: joy=%h fall=%h rst=%b expected 000/800/1", joy, joy_fall, btn_reset);
        end
        tick(1);
        checks++;
        if (btn_reset !== 1'b0) begin failures++; $display("FAIL hold_deassert: rst=%b expected 0", btn_reset); end
    endtask

    task automatic test_hold_reset;
        n_joy[11] = 1'b0;
        tick(40);
        rst_n = 1'b0;
        tick(1);
        checks++;
        if (joy !== 12'h000 || btn_reset !== 1'b0) begin
            failures++; $display("FAIL midhold_reset: joy=%h rst=%b expected 000/0", joy, btn_reset);
        end
        rst_n = 1'b1;
        tick(80);
        checks++;
        if (joy !== 12'h800 || btn_reset !== 1'b0) begin
            failures++; $display("FAIL rehold_80: joy=%h rst=%b expected 800/0", joy, btn_reset);
        end
        tick(1);
        checks++;
        if (btn_reset !== 1'b1) begin failures++; $display("FAIL rehold_81: rst=%b expected 1", btn_reset); end
        n_joy[11] = 1'b1;
        tick(20);
    endtask

    task automatic test_nmi;
        n_joy[10] = 1'b0;
        tick(18);
        checks++;
        if (joy_rise !== 12'h400 || btn_nmi !== 1'b0) begin
            failures++; $display("FAIL nmi_rise: rise=%h nmi=%b expected 400/0", joy_rise, btn_nmi);
        end
        tick(1);
        checks++;
        if (joy_rise !== 12'h000 || btn_nmi !== 1'b1) begin
            failures++; $display("FAIL nmi_pulse: rise=%h nmi=%b expected 000/1", joy_rise, btn_nmi);
        end
        tick(1);
        checks++;
        if (btn_nmi !== 1'b0) begin failures++; $display("FAIL nmi_width: nmi=%b expected 0", btn_nmi); end
        n_joy[10] = 1'b1;
        tick(20);
    endtask

    task automatic test_simultaneous;
        n_joy[3] = 1'b0;
        n_joy[9] = 1'b0;
        tick(18);
        checks++;
        if (joy_rise !== 12'h208 || joy !== 12'h208) begin
            failures++; $display("FAIL simul_rise: rise=%h joy=%h expected 208/208", joy_rise, joy);
        end
        tick(1);
        checks++;
        if (joy_rise !== 12'h000) begin failures++; $display("FAIL simul_width: rise=%h expected 000", joy_rise); end
        n_joy[3] = 1'b1;
        n_joy[9] = 1'b1;
        tick(18);
        checks++;
        if (joy_fall !== 12'h208 || joy !== 12'h000) begin
            failures++; $display("FAIL simul_fall: fall=%h joy=%h expected 208/000", joy_fall, joy);
        end
        tick(2);
    endtask

`ifdef JOY_AUTOFIRE_EN
    task automatic test_autofire;
        logic prev;
        int   changes, run;
        bit   seen;
        autofire_en = 2'b01;
        n_joy[4] = 1'b0;
        tick(18);
        checks++;
        if (joy_rise !== 12'h010) begin failures++; $display("FAIL af_rise: rise=%h expected 010", joy_rise); end
        prev = joy[4]; changes = 0; run = 0; seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            run++;
            checks++;
            if (joy_rise !== 12'h000) begin failures++; $display("FAIL af_no_rise cyc %0d: rise=%h expected 000", k, joy_rise); end
            if (joy[4] !== prev) begin
                if (seen) begin
                    checks++;
                    if (run != 4) begin failures++; $display("FAIL af_period: run=%0d expected 4", run); end
                end
                seen = 1; changes++; run = 0; prev = joy[4];
            end
        end
        checks++;
        if (changes < 9) begin failures++; $display("FAIL af_toggles: changes=%0d expected >=9", changes); end
        n_joy[4] = 1'b1;
        autofire_en = 2'b00;
        tick(20);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        n_joy = 12'hFFF;
        autofire_en = 2'b00;
        test_reset();
        test_press_release();
        test_glitch_bounce();
        test_hold();
        test_hold_reset();
        test_nmi();
        test_simultaneous();
`ifdef JOY_AUTOFIRE_EN
        test_autofire();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
